// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM round-robin arbiter.
package sdram_arb_pkg;

    // Default bus widths of the shared 16-bit Avalon-MM SDRAM port.
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 16;

    // Arbiter FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/sdram_rr_arbiter_pick.sv
// Combinational round-robin selector: returns the first pending requester
// found when searching upwards from last_grant+1, wrapping around.
module rr_pick #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     pick,
    output logic             valid
);

    logic [IDX_W-1:0] idx;

    // Scan every requester once, starting just after the previous owner.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before any branch, otherwise a latch is inferred.
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IDX_W'((int'(last_grant) + k) % N);
            if (!valid && pending[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_rr_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM master port between
// NUM_REQ engines. One transaction per grant, at most one read in flight.
module sdram_rr_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    // engine side
    input  logic [NUM_REQ-1:0]          req_read_n,
    input  logic [NUM_REQ-1:0]          req_write_n,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
    input  logic [NUM_REQ*DATA_W-1:0]   req_writedata,
    output logic [NUM_REQ-1:0]          req_waitrequest,
    output logic [NUM_REQ-1:0]          req_readdatavalid,
    output logic [DATA_W-1:0]           req_readdata,
    // SDRAM controller side
    output logic                        chipselect,
    output logic [1:0]                  byteenable,
    output logic                        read_n,
    output logic                        write_n,
    output logic [ADDR_W-1:0]           address,
    output logic [DATA_W-1:0]           writedata,
    input  logic                        waitrequest,
    input  logic                        readdatavalid,
    input  logic [DATA_W-1:0]           readdata,
    // status
    output logic [NUM_REQ-1:0]          grant,
    output logic                        timeout_err
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    // Registered state
    state_t             state_q,       state_d;
    logic [NUM_REQ-1:0] grant_q,       grant_d;
    logic [IDX_W-1:0]   last_grant_q,  last_grant_d;
    logic               is_read_q,     is_read_d;
    logic [CNT_W-1:0]   tmo_cnt_q,     tmo_cnt_d;
    logic               timeout_err_q, timeout_err_d;

    // Arbitration and granted-requester views
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] pick;
    logic               pick_valid;
    logic [IDX_W-1:0]   g_idx;
    logic               g_read;
    logic               g_write;
    logic               g_strobe;
    logic [ADDR_W-1:0]  g_addr;
    logic [DATA_W-1:0]  g_wdata;

    // A requester is pending while either of its strobes is low.
    assign pending = ~(req_read_n & req_write_n);

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .pending    (pending),
        .last_grant (last_grant_q),
        .pick       (pick),
        .valid      (pick_valid)
    );

    // Select the granted requester's strobes, address and data (all zero when idle).
    always_comb begin
        g_idx   = '0;
        g_read  = 1'b0;
        g_write = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                g_idx   = IDX_W'(i);
                g_read  = ~req_read_n[i];
                g_write = ~req_write_n[i];
                g_addr  = req_address[i*ADDR_W +: ADDR_W];
                g_wdata = req_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    // The strobe that was latched at grant time; a simultaneous read+write counts as a read.
    assign g_strobe = is_read_q ? g_read : g_write;

    // Next-state logic and SDRAM / engine handshake outputs.
    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        last_grant_d      = last_grant_q;
        is_read_d         = is_read_q;
        tmo_cnt_d         = tmo_cnt_q;
        timeout_err_d     = timeout_err_q;
        read_n            = 1'b1;
        write_n           = 1'b1;
        address           = '0;
        writedata         = '0;
        req_waitrequest   = '1;
        req_readdatavalid = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d   = pick;
                    is_read_d = |(pick & ~req_read_n);
                    state_d   = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                read_n          = is_read_q ? ~g_read : 1'b1;
                write_n         = is_read_q ? 1'b1 : ~g_write;
                address         = g_addr;
                writedata       = g_wdata;
                req_waitrequest = ~grant_q | {NUM_REQ{waitrequest}};
                if (!waitrequest && g_strobe) begin
                    if (is_read_q) begin
                        state_d   = ST_WAIT;
                        tmo_cnt_d = '0;
                    end else begin
                        state_d      = ST_IDLE;
                        last_grant_d = g_idx;
                        grant_d      = '0;
                    end
                end else if (!g_read && !g_write) begin
                    // Owner withdrew before acceptance; keep its priority slot.
                    state_d = ST_IDLE;
                    grant_d = '0;
                end
            end

            ST_WAIT: begin
                req_readdatavalid = grant_q & {NUM_REQ{readdatavalid}};
                if (readdatavalid) begin
                    state_d      = ST_IDLE;
                    last_grant_d = g_idx;
                    grant_d      = '0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                    last_grant_d  = g_idx;
                    grant_d       = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: reset values take effect immediately on reset, independent of clk.
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            last_grant_q  <= IDX_LAST;
            is_read_q     <= 1'b0;
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            is_read_q     <= is_read_d;
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign grant        = grant_q;
    assign timeout_err  = timeout_err_q;
    assign req_readdata = readdata;
    assign chipselect   = 1'b1;
    assign byteenable   = 2'b11;

endmodule

// File: tb/tb_sdram_rr_arbiter.sv
// Scoreboard bench for sdram_rr_arbiter: stimulus pushes expected SDRAM
// commands and read returns; a negedge monitor pops and compares them.
module tb_sdram_rr_arbiter;

    localparam int N   = 3;
    localparam int AW  = 32;
    localparam int DW  = 16;
    localparam int TMO = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_read_n, req_write_n;
    logic [N*AW-1:0]   req_address;
    logic [N*DW-1:0]   req_writedata;
    logic [N-1:0]      req_waitrequest, req_readdatavalid;
    logic [DW-1:0]     req_readdata;
    logic              chipselect;
    logic [1:0]        byteenable;
    logic              read_n, write_n;
    logic [AW-1:0]     address;
    logic [DW-1:0]     writedata;
    logic              waitrequest, readdatavalid;
    logic [DW-1:0]     readdata;
    logic [N-1:0]      grant;
    logic              timeout_err;

    sdram_rr_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_read_n        (req_read_n),
        .req_write_n       (req_write_n),
        .req_address       (req_address),
        .req_writedata     (req_writedata),
        .req_waitrequest   (req_waitrequest),
        .req_readdatavalid (req_readdatavalid),
        .req_readdata      (req_readdata),
        .chipselect        (chipselect),
        .byteenable        (byteenable),
        .read_n            (read_n),
        .write_n           (write_n),
        .address           (address),
        .writedata         (writedata),
        .waitrequest       (waitrequest),
        .readdatavalid     (readdatavalid),
        .readdata          (readdata),
        .grant             (grant),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_cmd;
        bit            is_write;
        logic [N-1:0]  gnt;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_cmd(input bit wr, input int g, input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.is_cmd   = 1'b1;
        e.is_write = wr;
        e.gnt      = N'(1 << g);
        e.addr     = a;
        e.data     = d;
        exp_q.push_back(e);
    endtask

    task automatic exp_rdv(input int g, input logic [DW-1:0] d);
        exp_t e;
        e.is_cmd   = 1'b0;
        e.is_write = 1'b0;
        e.gnt      = N'(1 << g);
        e.addr     = '0;
        e.data     = d;
        exp_q.push_back(e);
    endtask

    // Monitor: accepted SDRAM commands and forwarded read data are popped and compared.
    always @(negedge clk) begin
        if (!reset) begin
            if ((!read_n || !write_n) && !waitrequest) begin
                if (exp_q.size() == 0 || !exp_q[0].is_cmd) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_cmd: unexpected command addr=0x%0h grant=%b", address, grant);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_kind", 64'(!write_n), 64'(mon_e.is_write));
                    check("sb_grant", 64'(grant), 64'(mon_e.gnt));
                    check("sb_addr", 64'(address), 64'(mon_e.addr));
                    if (mon_e.is_write) check("sb_wdata", 64'(writedata), 64'(mon_e.data));
                end
            end
            if (|req_readdatavalid) begin
                if (exp_q.size() == 0 || exp_q[0].is_cmd) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_rdv: unexpected readdatavalid=%b data=0x%0h", req_readdatavalid, req_readdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_rdv", 64'(req_readdatavalid), 64'(mon_e.gnt));
                    check("sb_rdata", 64'(req_readdata), 64'(mon_e.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_read_n[i]               = !rd;
        req_write_n[i]              = !wr;
        req_address[i*AW +: AW]     = a;
        req_writedata[i*DW +: DW]   = d;
    endtask

    task automatic apply_reset();
        reset         = 1'b1;
        req_read_n    = '1;
        req_write_n   = '1;
        req_address   = '0;
        req_writedata = '0;
        waitrequest   = 1'b1;
        readdatavalid = 1'b0;
        readdata      = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        apply_reset();
        reset = 1'b1;
        tick();
        check("rst_read_n", 64'(read_n), 64'd1);
        check("rst_write_n", 64'(write_n), 64'd1);
        check("rst_address", 64'(address), 64'd0);
        check("rst_writedata", 64'(writedata), 64'd0);
        check("rst_req_waitrequest", 64'(req_waitrequest), 64'b111);
        check("rst_req_readdatavalid", 64'(req_readdatavalid), 64'd0);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        check("rst_chipselect", 64'(chipselect), 64'd1);
        check("rst_byteenable", 64'(byteenable), 64'b11);
        reset = 1'b0;

        // ---------------- 1: single read ----------------
        readdatavalid = 1'b1;
        readdata      = 16'hDEAD;
        at_neg();
        check("idle_rdv_ignored", 64'(req_readdatavalid), 64'd0);
        tick();
        readdatavalid = 1'b0;
        set_req(0, 1, 0, 32'd800, 16'h0);
        waitrequest = 1'b0;
        exp_cmd(0, 0, 32'd800, 16'h0);
        exp_rdv(0, 16'hF00D);
        at_neg();
        check("t1_idle_grant", 64'(grant), 64'd0);
        check("t1_idle_waitreq", 64'(req_waitrequest), 64'b111);
        tick();
        at_neg();
        check("t1_issue_grant", 64'(grant), 64'b001);
        check("t1_issue_waitreq", 64'(req_waitrequest), 64'b110);
        tick();
        set_req(0, 0, 0, 32'd0, 16'h0);
        at_neg();
        check("t1_wait_grant", 64'(grant), 64'b001);
        check("t1_wait_no_rdv", 64'(req_readdatavalid), 64'd0);
        check("t1_wait_read_n", 64'(read_n), 64'd1);
        tick();
        readdatavalid = 1'b1;
        readdata      = 16'hF00D;
        at_neg();
        check("t1_data_grant", 64'(grant), 64'b001);
        tick();
        readdatavalid = 1'b0;
        at_neg();
        check("t1_back_idle", 64'(grant), 64'd0);
        check("t1_readdata_bcast", 64'(req_readdata), 64'hF00D);
        tick();

        // ---------------- 2: contention from reset ----------------
        apply_reset();
        waitrequest = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 0, 1, 32'(100 + i), 16'(16'hA000 + i));
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) exp_cmd(1, i, 32'(100 + i), 16'(16'hA000 + i));
        repeat (12) tick();
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 32'd0, 16'h0);
        at_neg();
        check("t2_idle_after", 64'(grant), 64'd0);
        tick();

        // ---------------- 3: stalled write ----------------
        waitrequest = 1'b1;
        set_req(1, 0, 1, 32'd400000, 16'h1234);
        exp_cmd(1, 1, 32'd400000, 16'h1234);
        at_neg();
        tick();
        for (int k = 0; k < 3; k++) begin
            at_neg();
            check("t3_stall_write_n", 64'(write_n), 64'd0);
            check("t3_stall_addr", 64'(address), 64'd400000);
            check("t3_stall_waitreq", 64'(req_waitrequest), 64'b111);
            check("t3_stall_grant", 64'(grant), 64'b010);
            tick();
        end
        waitrequest = 1'b0;
        at_neg();
        check("t3_accept_write_n", 64'(write_n), 64'd0);
        check("t3_accept_addr", 64'(address), 64'd400000);
        check("t3_accept_waitreq", 64'(req_waitrequest), 64'b101);
        tick();
        set_req(1, 0, 0, 32'd0, 16'h0);
        at_neg();
        check("t3_done_write_n", 64'(write_n), 64'd1);
        tick();

        // ---------------- 4: read timeout ----------------
        set_req(2, 1, 0, 32'h3000, 16'h0);
        set_req(0, 0, 1, 32'h55, 16'hBEEF);
        exp_cmd(0, 2, 32'h3000, 16'h0);
        exp_cmd(1, 0, 32'h55, 16'hBEEF);
        at_neg();
        tick();
        at_neg();
        check("t4_issue_grant", 64'(grant), 64'b100);
        tick();
        set_req(2, 0, 0, 32'd0, 16'h0);
        for (int k = 0; k < TMO; k++) begin
            at_neg();
            check("t4_no_err_early", 64'(timeout_err), 64'd0);
            check("t4_wait_grant", 64'(grant), 64'b100);
            tick();
        end
        at_neg();
        check("t4_timeout_err", 64'(timeout_err), 64'd1);
        check("t4_idle_grant", 64'(grant), 64'd0);
        tick();
        at_neg();
        check("t4_next_grant", 64'(grant), 64'b001);
        tick();
        set_req(0, 0, 0, 32'd0, 16'h0);
        at_neg();
        check("t4_err_sticky", 64'(timeout_err), 64'd1);
        tick();

        // ---------------- 5: abort before acceptance ----------------
        waitrequest = 1'b1;
        set_req(2, 1, 0, 32'h3100, 16'h0);
        at_neg();
        tick();
        at_neg();
        check("t5_issue_grant", 64'(grant), 64'b100);
        check("t5_issue_read_n", 64'(read_n), 64'd0);
        tick();
        set_req(2, 0, 0, 32'd0, 16'h0);
        at_neg();
        check("t5_abort_read_n", 64'(read_n), 64'd1);
        tick();
        set_req(2, 1, 0, 32'h4000, 16'h0);
        set_req(0, 0, 1, 32'h66, 16'h7777);
        waitrequest = 1'b0;
        exp_cmd(0, 2, 32'h4000, 16'h0);
        exp_rdv(2, 16'h0BAD);
        exp_cmd(1, 0, 32'h66, 16'h7777);
        at_neg();
        check("t5_abort_idle", 64'(grant), 64'd0);
        tick();
        at_neg();
        check("t5_req2_keeps_priority", 64'(grant), 64'b100);
        tick();
        set_req(2, 0, 0, 32'd0, 16'h0);
        readdatavalid = 1'b1;
        readdata      = 16'h0BAD;
        at_neg();
        tick();
        readdatavalid = 1'b0;
        at_neg();
        tick();
        at_neg();
        check("t5_then_req0", 64'(grant), 64'b001);
        tick();
        set_req(0, 0, 0, 32'd0, 16'h0);

        // ---------------- 6: reset during WAIT_DATA ----------------
        set_req(1, 1, 0, 32'h5000, 16'h0);
        exp_cmd(0, 1, 32'h5000, 16'h0);
        at_neg();
        tick();
        at_neg();
        tick();
        set_req(1, 0, 0, 32'd0, 16'h0);
        #1;
        check("t6_pre_grant", 64'(grant), 64'b010);
        check("t6_pre_err", 64'(timeout_err), 64'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_read_n", 64'(read_n), 64'd1);
        check("t6_rst_write_n", 64'(write_n), 64'd1);
        check("t6_rst_grant", 64'(grant), 64'd0);
        check("t6_rst_err", 64'(timeout_err), 64'd0);
        check("t6_rst_waitreq", 64'(req_waitrequest), 64'b111);
        at_neg();
        tick();
        reset = 1'b0;
        at_neg();
        check("t6_post_grant", 64'(grant), 64'd0);
        tick();

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
